// File: rtl/seq_pkg.sv
// Types and defaults shared by the serializer, the Moore sequence detector and their benches.
package seq_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int LEN_W_DEF = 4;
  localparam int DIV_W_DEF = 4;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_e;

  // Detector state encodings, kept here so stimulus and checker agree on them
  typedef enum logic [2:0] {
    DET_A = 3'b000,
    DET_B = 3'b010,
    DET_C = 3'b110,
    DET_D = 3'b100,
    DET_E = 3'b011
  } det_state_e;
endpackage

// File: rtl/bit_pattern_serializer_if.sv
// Control/status bundle between a stimulus controller and the serializer.
interface bit_pattern_serializer_if #(
  parameter int WIDTH = seq_pkg::WIDTH_DEF,
  parameter int LEN_W = seq_pkg::LEN_W_DEF,
  parameter int DIV_W = seq_pkg::DIV_W_DEF
);
  logic [WIDTH-1:0] pattern_i;
  logic [LEN_W-1:0] len_i;
  logic [DIV_W-1:0] period_i;
  logic             start_i;
  logic             repeat_i;
  logic             stop_i;
  logic             bit_o;
  logic             bit_valid_o;
  logic             busy_o;
  logic             done_o;
  logic [LEN_W-1:0] bit_idx_o;

  modport master (
    output pattern_i, len_i, period_i, start_i, repeat_i, stop_i,
    input  bit_o, bit_valid_o, busy_o, done_o, bit_idx_o
  );
  modport slave (
    input  pattern_i, len_i, period_i, start_i, repeat_i, stop_i,
    output bit_o, bit_valid_o, busy_o, done_o, bit_idx_o
  );
endinterface

// File: rtl/bit_pattern_serializer_timer.sv
// Per-bit hold timer: down-counter reloaded at each bit boundary, ticks when it reaches 0.
module bit_period_timer #(
  parameter int DIV_W = seq_pkg::DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] reload,
  input  logic             load,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)             cnt_q <= '0;
    else if (load)          cnt_q <= reload;
    else if (cnt_q != '0)   cnt_q <= cnt_q - DIV_W'(1);
  end

  assign tick = (cnt_q == '0);
endmodule

// File: rtl/bit_pattern_serializer.sv
// Serial stimulus source: shifts a captured pattern out LSB first, each bit held period+1 clocks.
module bit_pattern_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input logic                     clk,
  input logic                     rst_n,
  bit_pattern_serializer_if.slave bus
);
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d, shreg_q, shreg_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  logic [DIV_W-1:0] per_q, per_d, reload;
  logic             rep_q, rep_d, done_q, done_d;
  logic             load, tick;

  bit_period_timer #(.DIV_W(DIV_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (reload),
    .load   (load),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      shreg_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      per_q   <= '0;
      rep_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      shreg_q <= shreg_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
      rep_q   <= rep_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    shreg_d = shreg_q;
    len_d   = len_q;
    idx_d   = idx_q;
    per_d   = per_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    load    = 1'b0;
    reload  = per_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i && bus.len_i != '0) begin
          state_d = SHIFT;
          pat_d   = bus.pattern_i;
          shreg_d = bus.pattern_i;
          len_d   = (bus.len_i > WIDTH_L) ? WIDTH_L : bus.len_i;
          per_d   = bus.period_i;
          rep_d   = bus.repeat_i;
          idx_d   = '0;
          load    = 1'b1;
          reload  = bus.period_i;
        end
      end
      SHIFT: begin
        // Abort wins over an end-of-pass on the same edge
        if (bus.stop_i) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (tick) begin
          load = 1'b1;
          if (idx_q == len_q - LEN_W'(1)) begin
            done_d  = 1'b1;
            idx_d   = '0;
            shreg_d = pat_q;
            if (!rep_q) state_d = IDLE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            shreg_d = shreg_q >> 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o      = (state_q == SHIFT);
  assign bus.bit_valid_o = (state_q == SHIFT);
  assign bus.bit_o       = (state_q == SHIFT) & shreg_q[0];
  assign bus.bit_idx_o   = idx_q;
  assign bus.done_o      = done_q;
endmodule

// File: tb/tb_bit_pattern_serializer.sv
// Directed bench for bit_pattern_serializer, including a detector-state walk on bit_o.
module tb_bit_pattern_serializer;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bit_pattern_serializer_if #(.WIDTH(8), .LEN_W(4), .DIV_W(4)) bus ();

  bit_pattern_serializer #(.WIDTH(8), .LEN_W(4), .DIV_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Overlapping Moore detector for 1101
  function automatic det_state_e det_next(input det_state_e s, input logic x);
    case (s)
      DET_A:   return x ? DET_B : DET_A;
      DET_B:   return x ? DET_C : DET_A;
      DET_C:   return x ? DET_C : DET_D;
      DET_D:   return x ? DET_E : DET_A;
      default: return x ? DET_C : DET_A;
    endcase
  endfunction

  task automatic start_pass(input logic [7:0] pat, input logic [3:0] len,
                            input logic [3:0] per, input logic rep);
    bus.pattern_i = pat;
    bus.len_i     = len;
    bus.period_i  = per;
    bus.repeat_i  = rep;
    bus.start_i   = 1'b1;
    step();
    bus.start_i   = 1'b0;
  endtask

  logic [3:0] b1011 [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic       ba5   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  det_state_e det_exp [4] = '{DET_B, DET_C, DET_D, DET_E};

  initial begin
    logic seen;
    det_state_e det;
    rst_n = 1'b0;
    bus.pattern_i = '0; bus.len_i = '0; bus.period_i = '0;
    bus.start_i = 1'b0; bus.repeat_i = 1'b0; bus.stop_i = 1'b0;
    step(); step();
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_valid", 32'(bus.bit_valid_o), 0);
    chk("rst_bit", 32'(bus.bit_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_idx", 32'(bus.bit_idx_o), 0);
    rst_n = 1'b1;
    step();

    // 1: 1011 LSB first, period 0
    start_pass(8'b0000_1011, 4'd4, 4'd0, 1'b0);
    chk("t1_busy", 32'(bus.busy_o), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_bit%0d", i), 32'(bus.bit_o), 32'(b1011[i][0]));
      chk($sformatf("t1_idx%0d", i), 32'(bus.bit_idx_o), i);
      chk($sformatf("t1_valid%0d", i), 32'(bus.bit_valid_o), 1);
      chk($sformatf("t1_nodone%0d", i), 32'(bus.done_o), 0);
      step();
    end
    chk("t1_done", 32'(bus.done_o), 1);
    chk("t1_idle", 32'(bus.busy_o), 0);
    chk("t1_bit0", 32'(bus.bit_o), 0);
    chk("t1_idx_clr", 32'(bus.bit_idx_o), 0);
    step();
    chk("t1_done_pulse", 32'(bus.done_o), 0);

    // 2: period 2 -> 3 cycles per bit
    start_pass(8'b0000_1011, 4'd4, 4'd2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("t2_bit%0d_%0d", i, j), 32'(bus.bit_o), 32'(b1011[i][0]));
        chk($sformatf("t2_idx%0d_%0d", i, j), 32'(bus.bit_idx_o), i);
        seen |= bus.done_o;
        step();
      end
    chk("t2_early_done", 32'(seen), 0);
    chk("t2_done", 32'(bus.done_o), 1);
    chk("t2_idle", 32'(bus.busy_o), 0);
    step();
    chk("t2_done_once", 32'(bus.done_o), 0);

    // 3: repeat mode, then abort
    start_pass(8'b0000_0001, 4'd2, 4'd0, 1'b1);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("t3_bit%0d_%0d", p, i), 32'(bus.bit_o), (i == 0) ? 1 : 0);
        chk($sformatf("t3_done%0d_%0d", p, i), 32'(bus.done_o), (p > 0 && i == 0) ? 1 : 0);
        chk($sformatf("t3_busy%0d_%0d", p, i), 32'(bus.busy_o), 1);
        step();
      end
    chk("t3_wrap_done", 32'(bus.done_o), 1);
    bus.stop_i = 1'b1;
    step();
    bus.stop_i = 1'b0;
    chk("t3_stop_busy", 32'(bus.busy_o), 0);
    chk("t3_stop_bit", 32'(bus.bit_o), 0);
    chk("t3_stop_done", 32'(bus.done_o), 0);
    step();
    chk("t3_stop_done2", 32'(bus.done_o), 0);

    // 4a: len 0 is ignored
    start_pass(8'hFF, 4'd0, 4'd0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen |= bus.busy_o | bus.done_o;
      step();
    end
    chk("t4_len0", 32'(seen), 0);

    // 4b: len 15 clamps to 8
    start_pass(8'hA5, 4'd15, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_bit%0d", i), 32'(bus.bit_o), 32'(ba5[i]));
      chk($sformatf("t4_nodone%0d", i), 32'(bus.done_o), 0);
      step();
    end
    chk("t4_done", 32'(bus.done_o), 1);
    chk("t4_idle", 32'(bus.busy_o), 0);
    step();

    // 5a: restart mid-pass is ignored
    start_pass(8'b0000_1011, 4'd4, 4'd0, 1'b0);
    bus.pattern_i = 8'hFF; bus.len_i = 4'd2; bus.period_i = 4'd3; bus.start_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_bit%0d", i), 32'(bus.bit_o), 32'(b1011[i][0]));
      chk($sformatf("t5_idx%0d", i), 32'(bus.bit_idx_o), i);
      step();
    end
    bus.start_i = 1'b0;
    chk("t5_done", 32'(bus.done_o), 1);
    step();

    // 5b: reset at bit 2
    start_pass(8'b0000_1011, 4'd4, 4'd0, 1'b0);
    step(); step();
    chk("t5_at_bit2", 32'(bus.bit_idx_o), 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_rst_busy", 32'(bus.busy_o), 0);
    chk("t5_rst_valid", 32'(bus.bit_valid_o), 0);
    chk("t5_rst_bit", 32'(bus.bit_o), 0);
    chk("t5_rst_idx", 32'(bus.bit_idx_o), 0);
    chk("t5_rst_done", 32'(bus.done_o), 0);
    step();
    chk("t5_rst_done2", 32'(bus.done_o), 0);

    // 6: detector walk A->B->C->D->E
    det = DET_A;
    start_pass(8'b0000_1011, 4'd4, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      det = det_next(det, bus.bit_valid_o & bus.bit_o);
      chk($sformatf("t6_det%0d", i), 32'(det), 32'(det_exp[i]));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
